fifo_ms_lvl: RTL and testbench

Parametrised multi-stream FIFO for the dataflow fabric: one tagged write port feeds FLUX independent circular queues, and a one-hot read port drains them. It extends the basic multi-stream FIFO with occupancy counters per stream, an almost-full threshold, safe handling of full and empty streams, arbitrary (non-power-of-two) depth, and optional sticky error flags. It sits between a tagged producer and per-stream consumer actors.

---
 rtl/fifo_ms_lvl.sv | 168 ++++++++++++++++
 tb/tb_fifo_ms_lvl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ms_lvl.sv
// Multi-stream FIFO: one tagged write port, FLUX circular queues with level counters,
// one-hot read port. Define FIFO_MS_ERR_EN to build the sticky err_ovf/err_udf flags.

module fifo_ms_lvl_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic                  err_clr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [CNT_WIDTH-1:0]  lvl_o,
  output logic                  ovf_o,
  output logic                  udf_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LVL_MAX = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [CNT_WIDTH-1:0]  lvl_q, lvl_d;
  logic                  rd_ok, wr_ok;

  // A full stream still takes a write when its head leaves in the same cycle.
  assign rd_ok = rd_i && (lvl_q != '0);
  assign wr_ok = wr_i && ((lvl_q != LVL_MAX) || rd_ok);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wp_d  = wr_ok ? ptr_inc(wp_q) : wp_q;
    rp_d  = rd_ok ? ptr_inc(rp_q) : rp_q;
    lvl_d = lvl_q;
    case ({wr_ok, rd_ok})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q] <= data_i;
  end

  assign head_o = mem_q[rp_q];
  assign lvl_o  = lvl_q;

`ifdef FIFO_MS_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // A new event wins over a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_i && !wr_ok) ovf_d = 1'b1;
    if (rd_i && !rd_ok) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  logic unused_clr;
  assign unused_clr = err_clr_i;
  assign ovf_o      = 1'b0;
  assign udf_o      = 1'b0;
`endif
endmodule

module fifo_ms_lvl #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  parameter  int FLUX       = 2,
  parameter  int AFULL_THR  = DEPTH-1,
  localparam int TAG_WIDTH  = $clog2(FLUX),
  localparam int CNT_WIDTH  = $clog2(DEPTH+1),
  localparam int WIDTH      = TAG_WIDTH+DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write,
  input  logic [WIDTH-1:0]          din,
  output logic [FLUX-1:0]           full,
  output logic [FLUX-1:0]           almost_full,
  input  logic [FLUX-1:0]           read,
  output logic [WIDTH-1:0]          dout,
  output logic [FLUX-1:0]           empty,
  output logic [FLUX*CNT_WIDTH-1:0] level,
  input  logic                      err_clr,
  output logic [FLUX-1:0]           err_ovf,
  output logic [FLUX-1:0]           err_udf
);
  localparam logic [CNT_WIDTH-1:0] LVL_MAX = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] LVL_AF  = CNT_WIDTH'(AFULL_THR);

  logic [TAG_WIDTH-1:0]                 wr_tag, rd_idx;
  logic                                 tag_ok, rd_any;
  logic [FLUX-1:0][DATA_WIDTH-1:0]      head;
  logic [FLUX-1:0][CNT_WIDTH-1:0]       lvl;

  assign wr_tag = din[WIDTH-1:DATA_WIDTH];
  assign tag_ok = int'(wr_tag) < FLUX;

  // Lowest set read bit wins; idx 0 when idle gives show-ahead of stream 0.
  always_comb begin
    rd_any = |read;
    rd_idx = '0;
    for (int k = FLUX-1; k >= 0; k--)
      if (read[k]) rd_idx = TAG_WIDTH'(k);
  end

  for (genvar k = 0; k < FLUX; k++) begin : g_s
    fifo_ms_lvl_stream #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_s (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (write && tag_ok && (wr_tag == TAG_WIDTH'(k))),
      .rd_i      (rd_any && (rd_idx == TAG_WIDTH'(k))),
      .err_clr_i (err_clr),
      .data_i    (din[DATA_WIDTH-1:0]),
      .head_o    (head[k]),
      .lvl_o     (lvl[k]),
      .ovf_o     (err_ovf[k]),
      .udf_o     (err_udf[k])
    );

    assign full[k]        = (lvl[k] == LVL_MAX);
    assign almost_full[k] = (lvl[k] >= LVL_AF);
    assign empty[k]       = (lvl[k] == '0);
  end

  assign level = lvl;
  assign dout  = {rd_idx, head[rd_idx]};
endmodule

// File: tb/tb_fifo_ms_lvl.sv
// Bench for fifo_ms_lvl: queue-based reference for a DEPTH=4/FLUX=2 instance,
// plus a DEPTH=5/FLUX=3 instance for pointer wrap and out-of-range tags.

module tb_fifo_ms_lvl;
  localparam bit ERR_EN =
`ifdef FIFO_MS_ERR_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr;
  logic       wr_a;
  logic [8:0] din_a, dout_a;
  logic [1:0] rd_a, full_a, af_a, empty_a, ovf_a, udf_a;
  logic [5:0] level_a;

  logic       wr_b;
  logic [9:0] din_b, dout_b;
  logic [2:0] rd_b, full_b, af_b, empty_b, ovf_b, udf_b;
  logic [8:0] level_b;

  fifo_ms_lvl #(.DATA_WIDTH(8), .DEPTH(4), .FLUX(2)) dut (
    .clk(clk), .rst(rst), .write(wr_a), .din(din_a), .full(full_a),
    .almost_full(af_a), .read(rd_a), .dout(dout_a), .empty(empty_a),
    .level(level_a), .err_clr(clr), .err_ovf(ovf_a), .err_udf(udf_a));

  fifo_ms_lvl #(.DATA_WIDTH(8), .DEPTH(5), .FLUX(3)) dut5 (
    .clk(clk), .rst(rst), .write(wr_b), .din(din_b), .full(full_b),
    .almost_full(af_b), .read(rd_b), .dout(dout_b), .empty(empty_b),
    .level(level_b), .err_clr(clr), .err_ovf(ovf_b), .err_udf(udf_b));

  int n_chk = 0, n_fail = 0;
  int ml[2];
  bit mo[2], mu[2];
  logic [7:0] q0[$], q1[$], q2[$];

  typedef struct {
    bit         w;
    logic [8:0] d;
    logic [1:0] r;
    logic [2:0] l0, l1;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, a, e);
    end
  endtask

  task automatic check_state_a();
    for (int k = 0; k < 2; k++) begin
      chk("level", 32'(level_a[k*3 +: 3]), 32'(ml[k]));
      chk("empty", 32'(empty_a[k]), 32'(ml[k] == 0));
      chk("full", 32'(full_a[k]), 32'(ml[k] == 4));
      chk("almost_full", 32'(af_a[k]), 32'(ml[k] >= 3));
      chk("err_ovf", 32'(ovf_a[k]), 32'(ERR_EN & mo[k]));
      chk("err_udf", 32'(udf_a[k]), 32'(ERR_EN & mu[k]));
    end
  endtask

  // One cycle on the 4x2 instance: check dout before the edge, state after it.
  task automatic cyc_a(input bit w, input logic [8:0] d, input logic [1:0] r, input bit c);
    int  ri, t;
    bit  rv, rok, wok, ev_o, ev_u;
    wr_a = w; din_a = d; rd_a = r; clr = c;
    rv = (r != 2'b00);
    ri = r[0] ? 0 : (r[1] ? 1 : 0);
    t  = int'(d[8]);
    #1;
    chk("dout_tag", 32'(dout_a[8]), 32'(ri[0]));
    if (ml[ri] > 0) chk("dout_data", 32'(dout_a[7:0]), 32'((ri == 0) ? q0[0] : q1[0]));
    rok  = rv && (ml[ri] > 0);
    wok  = w && ((ml[t] < 4) || (rok && ri == t));
    ev_o = w && !wok;
    ev_u = rv && !rok;
    if (rok) begin
      if (ri == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      ml[ri]--;
    end
    if (wok) begin
      if (t == 0) q0.push_back(d[7:0]); else q1.push_back(d[7:0]);
      ml[t]++;
    end
    for (int k = 0; k < 2; k++) begin
      mo[k] = (ev_o && t == k)  ? 1'b1 : (c ? 1'b0 : mo[k]);
      mu[k] = (ev_u && ri == k) ? 1'b1 : (c ? 1'b0 : mu[k]);
    end
    @(posedge clk); #1;
    check_state_a();
  endtask

  task automatic model_reset();
    ml = '{0, 0}; mo = '{0, 0}; mu = '{0, 0};
    q0.delete(); q1.delete(); q2.delete();
  endtask

  initial begin
    tbl[0] = '{1'b1, 9'h011, 2'b00, 3'd1, 3'd0};
    tbl[1] = '{1'b1, 9'h122, 2'b00, 3'd1, 3'd1};
    tbl[2] = '{1'b1, 9'h033, 2'b00, 3'd2, 3'd1};
    tbl[3] = '{1'b0, 9'h000, 2'b01, 3'd1, 3'd1};
    tbl[4] = '{1'b0, 9'h000, 2'b01, 3'd0, 3'd1};
    tbl[5] = '{1'b1, 9'h044, 2'b00, 3'd1, 3'd1};
    tbl[6] = '{1'b0, 9'h000, 2'b11, 3'd0, 3'd1};
    tbl[7] = '{1'b0, 9'h000, 2'b10, 3'd0, 3'd0};

    rst = 1'b0; clr = 1'b0;
    wr_a = 1'b0; din_a = '0; rd_a = '0;
    wr_b = 1'b0; din_b = '0; rd_b = '0;
    model_reset();
    #12;
    check_state_a();
    chk("rst_empty_b", 32'(empty_b), 32'h7);
    chk("rst_level_b", 32'(level_b), 32'h0);
    @(negedge clk) rst = 1'b1;

    // basic order, multi-hot read, show-ahead
    for (int i = 0; i < 8; i++) begin
      cyc_a(tbl[i].w, tbl[i].d, tbl[i].r, 1'b0);
      chk("tbl_l0", 32'(level_a[2:0]), 32'(tbl[i].l0));
      chk("tbl_l1", 32'(level_a[5:3]), 32'(tbl[i].l1));
    end

    // fill stream 1, overflow, full write+read, clear, drain
    for (int i = 0; i < 4; i++) cyc_a(1'b1, {1'b1, 8'(8'hA0 + i)}, 2'b00, 1'b0);
    chk("full1", 32'(full_a[1]), 32'h1);
    cyc_a(1'b1, 9'h1FF, 2'b00, 1'b0);
    chk("ovf_level", 32'(level_a[5:3]), 32'd4);
    chk("ovf_flag", 32'(ovf_a[1]), 32'(ERR_EN));
    cyc_a(1'b1, 9'h1EE, 2'b10, 1'b0);
    chk("full_wr_rd_level", 32'(level_a[5:3]), 32'd4);
    cyc_a(1'b0, 9'h000, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) cyc_a(1'b0, 9'h000, 2'b10, 1'b0);

    // underflow with simultaneous write on the empty stream, then clear
    cyc_a(1'b1, 9'h055, 2'b01, 1'b0);
    chk("udf_level0", 32'(level_a[2:0]), 32'd1);
    chk("udf_flag0", 32'(udf_a[0]), 32'(ERR_EN));
    cyc_a(1'b0, 9'h000, 2'b00, 1'b1);
    chk("udf_clr0", 32'(udf_a[0]), 32'h0);
    cyc_a(1'b0, 9'h000, 2'b10, 1'b1);   // event beats clear
    cyc_a(1'b0, 9'h000, 2'b01, 1'b0);
    cyc_a(1'b0, 9'h000, 2'b00, 1'b1);

    // DEPTH=5, FLUX=3: wrap pointers on stream 2
    wr_b = 1'b1; din_b = {2'd2, 8'h00}; rd_b = 3'b000;
    @(posedge clk); #1;
    q2.push_back(8'h00);
    chk("b_level2", 32'(level_b[8:6]), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      din_b = {2'd2, 8'(i * 7)}; rd_b = 3'b100;
      #1;
      chk("b_dout", 32'(dout_b), 32'({2'd2, q2[0]}));
      @(posedge clk); #1;
      void'(q2.pop_front());
      q2.push_back(8'(i * 7));
      chk("b_level_wrap", 32'(level_b[8:6]), 32'd1);
    end
    din_b = {2'd3, 8'hFF}; rd_b = 3'b000;
    @(posedge clk); #1;
    chk("b_badtag_level", 32'(level_b), 32'({3'd1, 3'd0, 3'd0}));
    chk("b_badtag_ovf", 32'(ovf_b), 32'h0);
    wr_b = 1'b0; rd_b = 3'b100;
    #1;
    chk("b_last", 32'(dout_b), 32'({2'd2, q2[0]}));
    @(posedge clk); #1;
    rd_b = 3'b000;
    chk("b_empty", 32'(empty_b), 32'h7);

    // async reset mid-burst
    cyc_a(1'b0, 9'h000, 2'b10, 1'b0);
    cyc_a(1'b1, 9'h0C1, 2'b00, 1'b0);
    cyc_a(1'b1, 9'h1C2, 2'b00, 1'b0);
    wr_a = 1'b1; din_a = 9'h0C3; wr_b = 1'b1; din_b = {2'd1, 8'h5A};
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_state_a();
    chk("arst_level_b", 32'(level_b), 32'h0);
    chk("arst_empty_b", 32'(empty_b), 32'h7);
    @(posedge clk); #1;
    chk("arst_hold", 32'(level_a), 32'h0);
    wr_a = 1'b0; wr_b = 1'b0;
    @(negedge clk) rst = 1'b1;
    cyc_a(1'b1, 9'h0D1, 2'b00, 1'b0);
    chk("post_rst_level0", 32'(level_a[2:0]), 32'd1);
    cyc_a(1'b0, 9'h000, 2'b01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
